// File: rtl/tc_sample_sequencer_pkg.sv
// Shared definitions for the thermocouple sample path: MAX6675 frame layout,
// tagged sample-word layout and sequencer state encodings.
package tc_sample_sequencer_pkg;

    localparam int DUMMY_BIT   = 15;
    localparam int TEMP_MSB    = 14;
    localparam int TEMP_LSB    = 3;
    localparam int OPEN_TC_BIT = 2;

    localparam int WORD_FAULT_BIT = 15;
    localparam int WORD_SEQ_MSB   = 14;
    localparam int WORD_SEQ_LSB   = 12;
    localparam int WORD_TEMP_MSB  = 11;
    localparam int WORD_TEMP_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TICK = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_PUSH      = 3'd5
    } seq_state_t;

    // A frame is faulty if the thermocouple is open or the dummy bit is not zero.
    function automatic logic [15:0] make_sample_word(input logic [15:0] raw, input logic [2:0] seq);
        logic [15:0] word;
        word = '0;
        word[WORD_FAULT_BIT]              = raw[OPEN_TC_BIT] | raw[DUMMY_BIT];
        word[WORD_SEQ_MSB:WORD_SEQ_LSB]   = seq;
        word[WORD_TEMP_MSB:WORD_TEMP_LSB] = raw[TEMP_MSB:TEMP_LSB];
        return word;
    endfunction

endpackage

// File: rtl/tc_sample_sequencer_tick_gen.sv
// Sample pacing counter: runs only while enabled and flags the last cycle of
// each period.
module tc_sample_sequencer_tick_gen #(
    parameter int PERIOD_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!enable || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/tc_sample_sequencer.sv
// Paces MAX6675 reads through spi_master, tags each frame with a fault bit and
// a rolling sequence number, and pushes it into the logger FIFO.
module tc_sample_sequencer
    import tc_sample_sequencer_pkg::*;
#(
    parameter int PERIOD_CYCLES = 25_000_000,
    parameter int ACK_TIMEOUT   = 16,
    parameter int DROP_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              spi_start,
    input  logic              spi_busy,
    input  logic [15:0]       spi_dout,
    output logic              fifo_wr_en,
    output logic [15:0]       fifo_din,
    input  logic              fifo_full,
    output logic              tc_fault,
    output logic [DROP_W-1:0] drop_count,
    output logic              active
);

    localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [ACK_W-1:0]  ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    seq_state_t       state;
    logic             tick;
    logic             pending;
    logic [2:0]       seq;
    logic [15:0]      raw_frame;
    logic [ACK_W-1:0] ack_cnt;
    logic [15:0]      push_word;
    logic             overrun;
    logic             ack_expired;
    logic             full_drop;
    logic             drop_evt;
    logic             unused_raw_bits;

    tc_sample_sequencer_tick_gen #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .tick  (tick)
    );

    assign push_word       = make_sample_word(raw_frame, seq);
    assign unused_raw_bits = ^raw_frame[1:0];

    // A tick landing on START belongs to the next sample, so it is not an overrun.
    assign overrun     = tick && pending && (state != ST_START);
    assign ack_expired = (state == ST_WAIT_ACK) && !spi_busy && (ack_cnt == ACK_LAST);
    assign full_drop   = (state == ST_PUSH) && fifo_full;
    assign drop_evt    = overrun || ack_expired || full_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (!enable) begin
            pending <= 1'b0;
        end else if (tick) begin
            pending <= 1'b1;
        end else if (state == ST_START) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (drop_evt && drop_count != DROP_MAX) begin
            drop_count <= drop_count + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            spi_start  <= 1'b0;
            fifo_wr_en <= 1'b0;
            fifo_din   <= '0;
            tc_fault   <= 1'b0;
            active     <= 1'b0;
            seq        <= '0;
            raw_frame  <= '0;
            ack_cnt    <= '0;
        end else begin
            spi_start  <= 1'b0;
            fifo_wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state  <= ST_WAIT_TICK;
                        active <= 1'b1;
                    end
                end
                ST_WAIT_TICK: begin
                    if (!enable) begin
                        state  <= ST_IDLE;
                        active <= 1'b0;
                    end else if (pending) begin
                        state     <= ST_START;
                        spi_start <= 1'b1;
                    end
                end
                ST_START: begin
                    ack_cnt <= '0;
                    state   <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (spi_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (ack_cnt == ACK_LAST) begin
                        state <= ST_WAIT_TICK;
                    end else begin
                        ack_cnt <= ack_cnt + ACK_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!spi_busy) begin
                        raw_frame <= spi_dout;
                        state     <= ST_PUSH;
                    end
                end
                // Fault status follows every decoded frame, even one the FIFO cannot take.
                ST_PUSH: begin
                    fifo_din <= push_word;
                    tc_fault <= push_word[WORD_FAULT_BIT];
                    if (!fifo_full) begin
                        fifo_wr_en <= 1'b1;
                        seq        <= seq + 3'd1;
                    end
                    if (enable) begin
                        state <= ST_WAIT_TICK;
                    end else begin
                        state  <= ST_IDLE;
                        active <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tc_sample_sequencer.sv
// Directed-plus-random bench for tc_sample_sequencer with an SPI responder and
// a transaction-level model of sequence numbers, faults and drops.
module tb_tc_sample_sequencer;

    localparam int PERIOD       = 50;
    localparam int ACK_TO       = 16;
    localparam int DW           = 3;
    localparam int DROP_SAT     = (1 << DW) - 1;
    localparam int START_BUDGET = 200;
    localparam int BUSY_LEN     = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          spi_start;
    logic          spi_busy;
    logic [15:0]   spi_dout;
    logic          fifo_wr_en;
    logic [15:0]   fifo_din;
    logic          fifo_full;
    logic          tc_fault;
    logic [DW-1:0] drop_count;
    logic          active;

    int checks = 0;
    int errors = 0;
    int seq_m  = 0;
    int drop_m = 0;
    bit fault_m = 1'b0;

    tc_sample_sequencer #(
        .PERIOD_CYCLES(PERIOD),
        .ACK_TIMEOUT  (ACK_TO),
        .DROP_W       (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .spi_start (spi_start),
        .spi_busy  (spi_busy),
        .spi_dout  (spi_dout),
        .fifo_wr_en(fifo_wr_en),
        .fifo_din  (fifo_din),
        .fifo_full (fifo_full),
        .tc_fault  (tc_fault),
        .drop_count(drop_count),
        .active    (active)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic int sat_add(input int v, input int n);
        return (v + n > DROP_SAT) ? DROP_SAT : v + n;
    endfunction

    function automatic logic [15:0] expected_word(input logic [15:0] frame, input int seq);
        int temp;
        int fault;
        temp  = (int'(frame) / 8) % 4096;
        fault = (frame[2] || frame[15]) ? 1 : 0;
        return 16'(fault * 32768 + (seq % 8) * 4096 + temp);
    endfunction

    task automatic wait_start(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < START_BUDGET; i++) begin
            @(negedge clk);
            if (spi_start) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // One full sample: answer the start pulse, hold busy, present the frame, check the push.
    task automatic applyStimulus(input logic [15:0] frame, input int busy_cycles, input bit full,
                                 input int drop_en_at, input int extra_drops);
        bit seen;
        logic [15:0] exp_word;
        fifo_full = full;
        wait_start(seen);
        checkOutput("spi_start_seen", 16'(seen), 16'd1);
        if (!seen) return;
        checkOutput("active_in_txn", 16'(active), 16'd1);
        spi_busy = 1'b1;
        spi_dout = 16'($urandom);
        for (int i = 0; i < busy_cycles; i++) begin
            @(negedge clk);
            if (i == drop_en_at) enable = 1'b0;
        end
        spi_busy = 1'b0;
        spi_dout = frame;
        @(negedge clk);
        spi_dout = 16'($urandom);
        checkOutput("wr_en_early", 16'(fifo_wr_en), 16'd0);
        @(negedge clk);
        exp_word = expected_word(frame, seq_m);
        fault_m  = frame[2] || frame[15];
        drop_m   = sat_add(drop_m, extra_drops + (full ? 1 : 0));
        if (!full) seq_m++;
        checkOutput("wr_en", 16'(fifo_wr_en), 16'(!full));
        checkOutput("fifo_din", fifo_din, exp_word);
        checkOutput("tc_fault", 16'(tc_fault), 16'(fault_m));
        checkOutput("drop_count", 16'(drop_count), 16'(drop_m));
    endtask

    initial begin
        bit seen;
        int starts;
        int writes;

        rst       = 1'b1;
        enable    = 1'b0;
        spi_busy  = 1'b0;
        spi_dout  = '0;
        fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_spi_start", 16'(spi_start), 16'd0);
        checkOutput("rst_wr_en", 16'(fifo_wr_en), 16'd0);
        checkOutput("rst_fifo_din", fifo_din, 16'h0000);
        checkOutput("rst_tc_fault", 16'(tc_fault), 16'd0);
        checkOutput("rst_drop", 16'(drop_count), 16'd0);
        checkOutput("rst_active", 16'(active), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_active", 16'(active), 16'd0);

        $display("[TB] basic sample and sequence increment");
        enable = 1'b1;
        applyStimulus(16'h0C80, BUSY_LEN, 1'b0, -1, 0);
        checkOutput("basic_word_const", fifo_din, 16'h0190);
        applyStimulus(16'($urandom) & 16'h7FF8, BUSY_LEN, 1'b0, -1, 0);

        $display("[TB] open thermocouple then healthy frame");
        applyStimulus(16'h0004, BUSY_LEN, 1'b0, -1, 0);
        applyStimulus(16'h0C80, BUSY_LEN, 1'b0, -1, 0);

        $display("[TB] FIFO full for three samples");
        for (int i = 0; i < 3; i++) applyStimulus(16'($urandom), BUSY_LEN, 1'b1, -1, 0);
        applyStimulus(16'($urandom), BUSY_LEN, 1'b0, -1, 0);

        $display("[TB] missing acknowledge");
        wait_start(seen);
        checkOutput("noack_start_seen", 16'(seen), 16'd1);
        starts = 1;
        for (int i = 1; i <= ACK_TO; i++) begin
            @(negedge clk);
            if (spi_start) starts++;
        end
        checkOutput("noack_drop_before", 16'(drop_count), 16'(drop_m));
        @(negedge clk);
        drop_m = sat_add(drop_m, 1);
        checkOutput("noack_drop_after", 16'(drop_count), 16'(drop_m));
        checkOutput("noack_single_start", 16'(starts), 16'd1);
        applyStimulus(16'($urandom), BUSY_LEN, 1'b0, -1, 0);

        // A 120-cycle transfer spans two ticks; only the second one finds pending already set.
        $display("[TB] overrun from a slow transfer");
        applyStimulus(16'($urandom), 120, 1'b0, -1, 1);
        applyStimulus(16'($urandom), BUSY_LEN, 1'b0, -1, 0);

        $display("[TB] drop counter saturation");
        for (int i = 0; i < 4; i++) applyStimulus(16'($urandom), BUSY_LEN, 1'b1, -1, 0);
        checkOutput("drop_saturated", 16'(drop_count), 16'(DROP_SAT));

        $display("[TB] sequence wrap over nine samples");
        for (int i = 0; i < 9; i++) applyStimulus(16'($urandom), BUSY_LEN, 1'b0, -1, 0);

        $display("[TB] enable dropped mid-transfer");
        applyStimulus(16'($urandom), BUSY_LEN, 1'b0, 20, 0);
        checkOutput("disable_active", 16'(active), 16'd0);
        starts = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge clk);
            if (spi_start) starts++;
        end
        checkOutput("disable_no_start", 16'(starts), 16'd0);

        $display("[TB] reset during transfer");
        enable = 1'b1;
        wait_start(seen);
        checkOutput("rst_txn_start_seen", 16'(seen), 16'd1);
        spi_busy = 1'b1;
        repeat (10) @(negedge clk);
        rst    = 1'b1;
        enable = 1'b0;
        #1;
        checkOutput("async_rst_spi_start", 16'(spi_start), 16'd0);
        checkOutput("async_rst_wr_en", 16'(fifo_wr_en), 16'd0);
        checkOutput("async_rst_fifo_din", fifo_din, 16'h0000);
        checkOutput("async_rst_tc_fault", 16'(tc_fault), 16'd0);
        checkOutput("async_rst_drop", 16'(drop_count), 16'd0);
        checkOutput("async_rst_active", 16'(active), 16'd0);
        @(negedge clk);
        rst      = 1'b0;
        spi_busy = 1'b0;
        spi_dout = 16'($urandom);
        writes   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_wr_en) writes++;
        end
        checkOutput("rst_no_write", 16'(writes), 16'd0);
        seq_m   = 0;
        drop_m  = 0;
        fault_m = 1'b0;
        enable  = 1'b1;
        applyStimulus(16'h0C80, BUSY_LEN, 1'b0, -1, 0);
        checkOutput("post_rst_word_const", fifo_din, 16'h0190);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
